// File: rtl/iter_divider.sv
// Iterative 32-bit radix-2 restoring divider with stream handshake; SIGNED selects two's-complement mode.
// Optional macro DIV_EARLY_EXIT_EN skips the iteration phase when the quotient is trivially zero or the divisor is zero.
module iter_divider #(
    parameter int SIGNED = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid,
    input  logic        m_axis_dout_tready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] quo_r;        // dividend magnitude shifts out MSB first while quotient bits shift in
    logic [31:0] dvs_r;
    logic [32:0] rem_r;
    logic [4:0]  cnt_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        div0_r;
    logic        tready_r;
    logic        dout_tvalid_r;
    logic [63:0] dout_tdata_r;

    logic        dvd_neg_s;
    logic        dvs_neg_s;
    logic [31:0] dvd_mag_s;
    logic [31:0] dvs_mag_s;
    logic        accept_s;
    logic        early_s;
    logic [33:0] shift_s;
    logic [33:0] trial_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        if (neg) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    // Operand magnitudes, accept decision, restoring step and final sign correction
    always_comb begin
        dvd_neg_s = (SIGNED != 0) && s_axis_dividend_tdata[31];
        dvs_neg_s = (SIGNED != 0) && s_axis_divisor_tdata[31];
        dvd_mag_s = magnitude(s_axis_dividend_tdata, dvd_neg_s);
        dvs_mag_s = magnitude(s_axis_divisor_tdata, dvs_neg_s);
        accept_s  = (state_r == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
`ifdef DIV_EARLY_EXIT_EN
        early_s   = (s_axis_divisor_tdata == 32'd0) || (dvd_mag_s < dvs_mag_s);
`else
        early_s   = 1'b0;
`endif
        shift_s   = {rem_r, quo_r[31]};
        trial_s   = shift_s - {2'b00, dvs_r};
        // A zero divisor reports all-ones; the remainder path restores the original dividend
        if (div0_r) begin
            quo_fix_s = 32'hFFFF_FFFF;
        end else if (q_neg_r) begin
            quo_fix_s = 32'd0 - quo_r;
        end else begin
            quo_fix_s = quo_r;
        end
        if (r_neg_r) begin
            rem_fix_s = 32'd0 - rem_r[31:0];
        end else begin
            rem_fix_s = rem_r[31:0];
        end
    end

    // Control FSM, datapath registers and registered stream outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= IDLE;
            quo_r         <= 32'd0;
            dvs_r         <= 32'd0;
            rem_r         <= 33'd0;
            cnt_r         <= 5'd0;
            q_neg_r       <= 1'b0;
            r_neg_r       <= 1'b0;
            div0_r        <= 1'b0;
            tready_r      <= 1'b1;
            dout_tvalid_r <= 1'b0;
            dout_tdata_r  <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dvs_r    <= dvs_mag_s;
                        cnt_r    <= 5'd0;
                        q_neg_r  <= dvd_neg_s ^ dvs_neg_s;
                        r_neg_r  <= dvd_neg_s;
                        div0_r   <= (s_axis_divisor_tdata == 32'd0);
                        tready_r <= 1'b0;
                        if (early_s) begin
                            quo_r   <= 32'd0;
                            rem_r   <= {1'b0, dvd_mag_s};
                            state_r <= FIX;
                        end else begin
                            quo_r   <= dvd_mag_s;
                            rem_r   <= 33'd0;
                            state_r <= CALC;
                        end
                    end else begin
                        tready_r <= 1'b1;
                    end
                end
                CALC: begin
                    if (!trial_s[33]) begin
                        rem_r <= trial_s[32:0];
                        quo_r <= {quo_r[30:0], 1'b1};
                    end else begin
                        rem_r <= shift_s[32:0];
                        quo_r <= {quo_r[30:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    dout_tdata_r  <= {quo_fix_s, rem_fix_s};
                    dout_tvalid_r <= 1'b1;
                    state_r       <= DONE;
                end
                DONE: begin
                    if (m_axis_dout_tready) begin
                        dout_tvalid_r <= 1'b0;
                        tready_r      <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        state_r       <= DONE;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    tready_r      <= 1'b1;
                    dout_tvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_divisor_tready  = tready_r;
    assign s_axis_dividend_tready = tready_r;
    assign m_axis_dout_tdata      = dout_tdata_r;
    assign m_axis_dout_tvalid     = dout_tvalid_r;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: a signed and an unsigned instance share stimulus and
// are checked against an arithmetic reference model; latency expectations follow DIV_EARLY_EXIT_EN.
module tb_iter_divider;

    typedef struct {
        logic [63:0] data;
        int          lat;
        int          acc;
    } exp_t;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] dvs_data, dvd_data;
    logic        dvs_valid, dvd_valid;
    logic        dout_ready;
    logic [1:0]  dvs_rdy, dvd_rdy, dout_valid;
    logic [63:0] dout_s, dout_u;

    exp_t q_s[$];
    exp_t q_u[$];
    exp_t cur [2];
    bit   seen [2];
    bit   have [2];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_divider #(.SIGNED(1)) u_sdiv (
        .clk(clk), .resetn(resetn),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(dvs_rdy[0]),
        .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(dvd_rdy[0]),
        .m_axis_dout_tdata(dout_s), .m_axis_dout_tvalid(dout_valid[0]), .m_axis_dout_tready(dout_ready)
    );

    iter_divider #(.SIGNED(0)) u_udiv (
        .clk(clk), .resetn(resetn),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(dvs_rdy[1]),
        .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(dvd_rdy[1]),
        .m_axis_dout_tdata(dout_u), .m_axis_dout_tvalid(dout_valid[1]), .m_axis_dout_tready(dout_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: truncating division in 64-bit arithmetic, zero divisor handled explicitly
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
        logic [31:0] m;
        m = (sgn && v[31]) ? (32'd0 - v) : v;
        return m;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        bit early;
        early = (b == 32'd0) || (mag(a, sgn) < mag(b, sgn));
        return (early && EARLY_EXIT) ? 1 : 33;
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.acc  = cyc;
        e.data = ref_div(a, b, 1'b1);
        e.lat  = ref_lat(a, b, 1'b1);
        q_s.push_back(e);
        e.data = ref_div(a, b, 1'b0);
        e.lat  = ref_lat(a, b, 1'b0);
        q_u.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(dvs_rdy == 2'b11 && dvd_rdy == 2'b11) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'(n), 64'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        dvd_data  = a;
        dvs_data  = b;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        @(posedge clk);
        #1;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        push(a, b);
        dvd_data  = $urandom;
        dvs_data  = $urandom;
    endtask

    task automatic mon(input int i);
        logic [63:0] d;
        d = (i == 0) ? dout_s : dout_u;
        if (dout_valid[i]) begin
            if (!seen[i]) begin
                seen[i] = 1'b1;
                if ((i == 0 && q_s.size() == 0) || (i == 1 && q_u.size() == 0)) begin
                    have[i] = 1'b0;
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result inst%0d: got %h expected no result", i, d);
                end else begin
                    if (i == 0) cur[i] = q_s.pop_front();
                    else        cur[i] = q_u.pop_front();
                    have[i] = 1'b1;
                    chk($sformatf("result_inst%0d", i), d, cur[i].data);
                    chk($sformatf("latency_inst%0d", i), 64'(cyc - cur[i].acc), 64'(cur[i].lat));
                end
            end else if (have[i]) begin
                chk($sformatf("hold_inst%0d", i), d, cur[i].data);
            end
        end else begin
            seen[i] = 1'b0;
        end
    endtask

    task automatic rand_ops(output logic [31:0] a, output logic [31:0] b);
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 6))
            0: ;
            1: b = $urandom_range(1, 255);
            2: b = 32'd0;
            3: a = 32'd0;
            4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            5: b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
            6: a = $urandom_range(0, 1000);
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] ra, rb;
        int n;
        resetn = 1'b0; dvs_valid = 1'b0; dvd_valid = 1'b0; dout_ready = 1'b1;
        dvs_data = 32'd0; dvd_data = 32'd0;
        fork
            forever begin
                @(negedge clk);
                mon(0);
                mon(1);
            end
            begin
                repeat (2) @(negedge clk);
                chk("reset_tvalid", 64'(dout_valid), 64'd0);
                chk("reset_tdata_s", dout_s, 64'd0);
                chk("reset_tdata_u", dout_u, 64'd0);
                chk("reset_tready", 64'({dvs_rdy, dvd_rdy}), 64'hF);
                resetn = 1'b1;

                issue(32'd7, 32'hFFFF_FFFE);
                issue(32'hFFFF_FFF9, 32'd2);
                issue(32'h8000_0000, 32'hFFFF_FFFF);
                issue(32'hFFFF_FFFF, 32'h10);
                issue(32'h1234_5678, 32'd0);
                issue(32'd3, 32'd10);

                // One operand valid alone must not be accepted
                wait_idle();
                dvd_data = 32'd1000; dvd_valid = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("single_valid_tready", 64'({dvs_rdy, dvd_rdy}), 64'hF);
                end
                dvs_data = 32'd9; dvs_valid = 1'b1;
                @(posedge clk);
                #1;
                dvd_valid = 1'b0; dvs_valid = 1'b0;
                push(32'd1000, 32'd9);

                // Backpressure: result held, new operands refused until consumed
                wait_idle();
                dout_ready = 1'b0;
                issue(32'hDEAD_BEEF, 32'h0000_1234);
                n = 0;
                while (dout_valid != 2'b11 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 100) chk("bp_timeout", 64'(dout_valid), 64'd3);
                dvd_valid = 1'b1; dvs_valid = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_tready", 64'({dvs_rdy, dvd_rdy}), 64'h0);
                    chk("bp_tvalid", 64'(dout_valid), 64'd3);
                end
                dout_ready = 1'b1;
                @(posedge clk);
                #1;
                dvd_valid = 1'b0; dvs_valid = 1'b0;
                @(negedge clk);
                chk("bp_release_tready", 64'({dvs_rdy, dvd_rdy}), 64'hF);
                chk("bp_release_tvalid", 64'(dout_valid), 64'd0);

                // Reset mid-calculation discards the in-flight division
                issue(32'h7654_3210, 32'd3);
                repeat (15) @(posedge clk);
                @(negedge clk);
                resetn = 1'b0;
                @(posedge clk);
                #1;
                resetn = 1'b1;
                void'(q_s.pop_back());
                void'(q_u.pop_back());
                @(negedge clk);
                chk("midreset_tvalid", 64'(dout_valid), 64'd0);
                chk("midreset_tready", 64'({dvs_rdy, dvd_rdy}), 64'hF);
                chk("midreset_tdata", dout_s | dout_u, 64'd0);
                issue(32'd100, 32'd7);

                for (int k = 0; k < 40; k++) begin
                    rand_ops(ra, rb);
                    issue(ra, rb);
                end

                n = 0;
                while ((q_s.size() != 0 || q_u.size() != 0 || dout_valid != 2'b00) && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) chk("drain_timeout", 64'(q_s.size() + q_u.size()), 64'd0);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Iterative 32-bit radix-2 divider; responder end of the EXE-stage divider stream handshake (divisor/dividend operand channels in, quotient/remainder result channel out).
- Drop-in for the divider IP slot in EXE: one instance with SIGNED=1 serves div.w/mod.w, one with SIGNED=0 serves div.wu/mod.wu.
- Accepts one operand pair, computes over 32 iteration cycles, then presents {quotient, remainder} until consumed.

Parameters:
- SIGNED, 1, 1 = two's-complement division, 0 = unsigned division.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- s_axis_divisor_tdata  input  32  divisor.
- s_axis_divisor_tvalid  input  1  divisor valid.
- s_axis_divisor_tready  output  1  divisor accept.
- s_axis_dividend_tdata  input  32  dividend.
- s_axis_dividend_tvalid  input  1  dividend valid.
- s_axis_dividend_tready  output  1  dividend accept.
- m_axis_dout_tdata  output  64  {quotient[63:32], remainder[31:0]}.
- m_axis_dout_tvalid  output  1  result valid.
- m_axis_dout_tready  input  1  result consumed; consumer may tie to 1.

Behaviour:
- Single clock clk; reset is synchronous, active-low on resetn.
- Reset values:
  - State IDLE.
  - m_axis_dout_tvalid = 0.
  - m_axis_dout_tdata = 0.
  - Both s_axis_*_tready = 1 from the first edge after reset.
- Both tready outputs are identical and high only in IDLE.
- Accept occurs on an edge where state is IDLE and both tvalid inputs are 1. If only one tvalid is high, nothing is captured and the block stays in IDLE.
- States:
  - IDLE -> CALC on accept. At the accept edge, capture operand magnitudes (abs value when SIGNED), sign of quotient (dividend sign xor divisor sign), sign of remainder (dividend sign), and load iteration counter = 0.
  - CALC: one restoring step per cycle, MSB first. Remainder register is 33 bits: shift in the next dividend bit, trial-subtract divisor, set the quotient bit if the result is non-negative. Counter increments each cycle; after step 31, go to FIX.
  - FIX: negate quotient/remainder per captured signs (SIGNED only), load dout_tdata, set dout_tvalid, go to DONE.
  - DONE: hold tdata and tvalid stable until an edge with m_axis_dout_tready = 1. On that edge clear tvalid and return to IDLE.
- Latency: m_axis_dout_tvalid rises 33 edges after the accept edge (32 CALC + 1 FIX). With dout_tready tied high, the next accept is possible 2 edges after tvalid rises.
- Divisor 0: quotient 0xFFFFFFFF, remainder = original dividend, for both SIGNED values; no negation is applied to this case.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of the magnitude arithmetic and needs no special case.
- Remainder is always 0 or has the dividend's sign; |remainder| < |divisor|.
- Operand tdata changing after the accept edge has no effect.
- resetn low in any state, including mid-CALC or DONE with tvalid high: at the next edge, return to IDLE, tvalid = 0, tdata = 0. The partial result is discarded.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE at accept, if the divisor is 0 or |dividend| < |divisor| (includes dividend 0), skip CALC and go directly to FIX.
  - Divisor 0: result as defined above.
  - Otherwise: quotient 0, remainder = original dividend.
  - tvalid rises 1 edge after the accept edge.
- Not defined: all divisions take the full 33-edge latency. Results are identical in both builds; only latency differs.

Test Plan:
- SIGNED=1, dividend 7, divisor 0xFFFFFFFE (-2) -> dout = {0xFFFFFFFD, 0x00000001}, tvalid 33 edges after accept.
- SIGNED=1, dividend 0xFFFFFFF9 (-7), divisor 2 -> {0xFFFFFFFD, 0xFFFFFFFF}. Then 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}.
- SIGNED=0, dividend 0xFFFFFFFF, divisor 0x10 -> {0x0FFFFFFF, 0x0000000F}. Divisor 0 with dividend 0x12345678 -> {0xFFFFFFFF, 0x12345678}.
- Only dividend_tvalid high for 5 cycles, then divisor_tvalid raised -> no accept until both are high; treadys stay 1 throughout IDLE.
- dout_tready held 0 for 10 cycles after tvalid -> tdata/tvalid stable and treadys 0; new operands are not accepted until the tready=1 edge.
- resetn pulsed low at CALC cycle 15 -> tvalid 0, treadys 1 after the next edge; a following 100/7 returns {14, 2} with normal latency. With DIV_EARLY_EXIT_EN defined, 3/10 -> {0, 3} one edge after accept.
